// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode definitions: reset PC, NOP encoding, opcodes, fetch packet.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;
  localparam int unsigned FETCH_PKT_W      = 64;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'h03,
    OPC_OP_IMM = 7'h13,
    OPC_AUIPC  = 7'h17,
    OPC_STORE  = 7'h23,
    OPC_OP     = 7'h33,
    OPC_LUI    = 7'h37,
    OPC_BRANCH = 7'h63,
    OPC_JALR   = 7'h67,
    OPC_JAL    = 7'h6F,
    OPC_SYSTEM = 7'h73
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with flush; head is shown combinationally.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    do_push = push_i && ((count_q != (AW+1)'(DEPTH)) || do_pop);
    head_o  = mem_q[rd_q];
    count_o = count_q;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Flush beats a same-cycle push/pop: the entries are discarded anyway.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: credit-limited imem requests, tag/instruction FIFOs, redirect kill.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched/perf_killed counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
`endif
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 2;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] kill_cnt_q, kill_cnt_d;
  logic [CW-1:0] outstanding, fifo_count;
  logic [SW-1:0] credit_used;
  logic [31:0]   tag_pc;
  fetch_pkt_t    head;
  logic          req_fire, rsp_live, rsp_kill, id_fire;
  logic          unused_redirect_lsbs;

  always_comb begin
    credit_used    = SW'(outstanding) + SW'(fifo_count) + SW'(kill_cnt_q);
    imem_req_valid = !rst && !redirect_valid && (credit_used < SW'(FIFO_DEPTH));
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_kill       = imem_rsp_valid && (kill_cnt_q != '0);
    rsp_live       = imem_rsp_valid && (kill_cnt_q == '0);
    id_fire        = id_valid && id_ready;
    unused_redirect_lsbs = ^redirect_pc[1:0];
  end

  // Killed responses are always older than live ones, so they never pop tags;
  // on redirect the live count migrates into kill_cnt and the tag FIFO is flushed.
  always_comb begin
    pc_d       = pc_q;
    kill_cnt_d = kill_cnt_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      kill_cnt_d = outstanding + kill_cnt_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (rsp_kill) kill_cnt_d = kill_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      kill_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect_valid),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (rsp_live),
    .head_o  (tag_pc),
    .count_o (outstanding)
  );

  fetch_fifo #(.WIDTH(FETCH_PKT_W), .DEPTH(FIFO_DEPTH)) u_inst_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (redirect_valid),
    .push_i  (rsp_live),
    .data_i  ({tag_pc, imem_rsp_data}),
    .pop_i   (id_fire),
    .head_o  (head),
    .count_o (fifo_count)
  );

  always_comb begin
    id_valid = (fifo_count != '0);
    id_inst  = id_valid ? head.inst : NOP_INST;
    id_pc    = id_valid ? head.pc   : pc_q;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_killed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_killed_q  <= '0;
    end else begin
      if (id_fire) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (imem_rsp_valid && ((kill_cnt_q != '0) || redirect_valid))
        perf_killed_q <= perf_killed_q + 32'd1;
    end
  end

  always_comb begin
    perf_fetched = perf_fetched_q;
    perf_killed  = perf_killed_q;
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with an in-order, fixed/random-latency imem model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int unsigned DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_killed;
`endif

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_killed    (perf_killed)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    int unsigned cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned gen = 0;
  int unsigned ready_mode = 0;
  bit          rand_id = 0;
  bit          chk_lat = 0;
  bit          rst_chk = 0;
  int unsigned fetched_exp = 0;
  int unsigned killed_exp = 0;
  logic [31:0] exp_pc;
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];
  int unsigned pend_gen[$];
  exp_t        exp_q[$];
  logic [31:0] got_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic cycle();
    exp_t        e;
    int unsigned due;
    if (rst) begin
      pend_addr.delete(); pend_due.delete(); pend_gen.delete();
      exp_q.delete();
      exp_pc = RESET_PC;
      fetched_exp = 0;
      killed_exp = 0;
      imem_rsp_valid = 1'b0;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr[0]);
      if (pend_gen[0] != gen || redirect_valid) killed_exp++;
      void'(pend_addr.pop_front()); void'(pend_due.pop_front()); void'(pend_gen.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    imem_req_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (rand_id) id_ready = 1'($urandom_range(0, 1));
    #1;
    if (rst) begin
      if (rst_chk) begin
        checks++;
        if (id_valid !== 1'b0 || id_inst !== NOP_INST || id_pc !== RESET_PC ||
            imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
          errors++;
          $display("FAIL reset_state got v=%b inst=%h pc=%h rv=%b ra=%h exp v=0 inst=%h pc=%h rv=0 ra=%h",
                   id_valid, id_inst, id_pc, imem_req_valid, imem_req_addr, NOP_INST, RESET_PC, RESET_PC);
        end
      end
    end else begin
      checks++;
      if (id_valid) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL id_unexpected got pc=%h exp none", id_pc);
        end else begin
          e = exp_q[0];
          if (id_pc !== e.pc || id_inst !== mem_word(e.pc)) begin
            errors++;
            $display("FAIL id_data got pc=%h inst=%h exp pc=%h inst=%h", id_pc, id_inst, e.pc, mem_word(e.pc));
          end
          if (chk_lat) begin
            checks++;
            if (cyc - e.cyc != 2) begin
              errors++;
              $display("FAIL id_latency got %0d exp 2", cyc - e.cyc);
            end
          end
          if (id_ready) begin
            void'(exp_q.pop_front());
            got_q.push_back(id_pc);
            fetched_exp++;
          end
        end
      end else if (id_inst !== NOP_INST) begin
        errors++;
        $display("FAIL id_nop got %h exp %h", id_inst, NOP_INST);
      end
      if (imem_req_valid) begin
        checks++;
        if (imem_req_addr !== exp_pc) begin
          errors++;
          $display("FAIL req_addr got %h exp %h", imem_req_addr, exp_pc);
        end
        if (imem_req_ready) begin
          due = cyc + lat;
          if (pend_due.size() > 0 && due <= pend_due[$]) due = pend_due[$] + 1;
          pend_addr.push_back(imem_req_addr); pend_due.push_back(due); pend_gen.push_back(gen);
          exp_q.push_back('{pc: exp_pc, cyc: cyc});
          exp_pc = exp_pc + 32'd4;
        end
      end
      if (redirect_valid) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL req_in_redirect got %b exp 0", imem_req_valid);
        end
        exp_q.delete();
        exp_pc = {redirect_pc[31:2], 2'b00};
        gen++;
      end
      checks++;
      if (pend_addr.size() > DEPTH) begin
        errors++;
        $display("FAIL inflight got %0d exp <=%0d", pend_addr.size(), DEPTH);
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1; redirect_valid = 1'b0;
    rst_chk = 0;
    cycle();
    rst_chk = 1;
    repeat (n - 1) cycle();
    rst = 1'b0; rst_chk = 0;
  endtask

  task automatic wait_inflight2();
    for (int i = 0; i < 10 && pend_addr.size() < 2; i++) cycle();
    checks++;
    if (pend_addr.size() != 2) begin
      errors++;
      $display("FAIL wait_inflight got %0d exp 2", pend_addr.size());
    end
  endtask

  task automatic check_first(input string name, input logic [31:0] exp);
    checks++;
    if (got_q.size() == 0 || got_q[0] !== exp) begin
      errors++;
      $display("FAIL %s got %h (n=%0d) exp %h", name, (got_q.size() > 0) ? got_q[0] : 32'hX, got_q.size(), exp);
    end
  endtask

  task automatic test_reset();
    apply_reset(3);
  endtask

  task automatic test_stream();
    apply_reset(2);
    lat = 1; id_ready = 1'b1; got_q.delete();
    chk_lat = 1;
    repeat (14) cycle();
    chk_lat = 0;
    checks++;
    if (got_q.size() < 3 || got_q[0] !== 32'h0 || got_q[1] !== 32'h4 || got_q[2] !== 32'h8) begin
      errors++;
      $display("FAIL stream_order got n=%0d exp 0,4,8", got_q.size());
    end
  endtask

  task automatic test_backpressure();
    apply_reset(2);
    lat = 1; id_ready = 1'b0;
    repeat (10) cycle();
    checks++;
    if (exp_q.size() != 2 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got accepted=%0d req_valid=%b exp 2 0", exp_q.size(), imem_req_valid);
    end
    id_ready = 1'b1; got_q.delete();
    repeat (4) cycle();
    checks++;
    if (got_q.size() < 2 || got_q[0] !== 32'h0 || got_q[1] !== 32'h4) begin
      errors++;
      $display("FAIL bp_release got n=%0d exp 0,4", got_q.size());
    end
  endtask

  task automatic test_redirect();
    apply_reset(2);
    lat = 3; id_ready = 1'b1;
    wait_inflight2();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cycle();
    redirect_valid = 1'b0; got_q.delete();
    repeat (15) cycle();
    check_first("redirect_first", 32'h100);
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (perf_killed !== 32'd2) begin
      errors++;
      $display("FAIL perf_killed_redirect got %0d exp 2", perf_killed);
    end
`endif
  endtask

  task automatic test_redirect_with_rsp();
    apply_reset(2);
    lat = 2; id_ready = 1'b1;
    for (int i = 0; i < 20 && !(pend_addr.size() > 0 && pend_due[0] == cyc); i++) cycle();
    checks++;
    if (!(pend_addr.size() > 0 && pend_due[0] == cyc)) begin
      errors++;
      $display("FAIL wait_rsp got none exp response due");
    end
    redirect_valid = 1'b1; redirect_pc = 32'h180;
    cycle();
    redirect_valid = 1'b0; got_q.delete();
    repeat (12) cycle();
    check_first("redirect_rsp_first", 32'h180);
  endtask

  task automatic test_back_to_back();
    apply_reset(2);
    lat = 3; id_ready = 1'b1;
    wait_inflight2();
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cycle();
    redirect_pc = 32'h303;
    cycle();
    redirect_valid = 1'b0; got_q.delete();
    repeat (20) cycle();
    check_first("b2b_first", 32'h300);
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i] < 32'h300) begin
        errors++;
        $display("FAIL b2b_stale got %h exp >=300", got_q[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset(2);
    lat = 1; id_ready = 1'b0;
    repeat (8) cycle();
    checks++;
    if (id_valid !== 1'b1 || exp_q.size() != 2) begin
      errors++;
      $display("FAIL full_before_rst got v=%b n=%0d exp 1 2", id_valid, exp_q.size());
    end
    apply_reset(2);
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL restart_fetch got v=%b addr=%h exp 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    id_ready = 1'b1; got_q.delete();
    repeat (6) cycle();
    check_first("restart_first", RESET_PC);
  endtask

  task automatic test_random();
    apply_reset(2);
    ready_mode = 1; rand_id = 1;
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 3);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else redirect_pc = $urandom;
      cycle();
    end
    redirect_valid = 1'b0; rand_id = 0; id_ready = 1'b1; ready_mode = 2;
    repeat (20) cycle();
    checks++;
    if (exp_q.size() != 0 || pend_addr.size() != 0) begin
      errors++;
      $display("FAIL random_drain got exp=%0d pend=%0d exp 0 0", exp_q.size(), pend_addr.size());
    end
    ready_mode = 0;
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    checks++;
    if (perf_fetched !== fetched_exp || perf_killed !== killed_exp) begin
      errors++;
      $display("FAIL perf_counts got f=%0d k=%0d exp f=%0d k=%0d", perf_fetched, perf_killed, fetched_exp, killed_exp);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1; exp_pc = RESET_PC;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_with_rsp();
    test_back_to_back();
    test_reset_midstream();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
